// File: rtl/decoder_scan_reg.sv
// Registered one-hot decoder with auto-scan ring; d/idx/busy/wrap update one cycle after inputs.
// No backpressure: en gates output and advance, clr > load > scan step.
module decoder_scan_reg #(
  parameter int SEL_W = 3,
  parameter int DIV   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  mode,
  input  logic                  dir,
  input  logic                  en,
  input  logic [SEL_W-1:0]      s,
  output logic [2**SEL_W-1:0]   d,
  output logic [SEL_W-1:0]      idx,
  output logic                  busy,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRE_MAX = PW'(DIV - 1);
  localparam logic [SEL_W-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     pre, pre_n;
  logic [SEL_W-1:0]  idx_n;
  logic              wrap_n;
  logic              busy_n;
  logic [OUT_W-1:0]  d_n;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    pre_n   = pre;
    wrap_n  = 1'b0;
    if (clr) begin
      state_n = IDLE;
      idx_n   = '0;
      pre_n   = '0;
    end else if (load) begin
      state_n = mode ? SCAN : DECODE;
      idx_n   = s;
      pre_n   = '0;
    end else if (state == SCAN && en) begin
      if (pre == PRE_MAX) begin
        pre_n = '0;
        if (dir) begin
          idx_n  = idx - SEL_W'(1);
          wrap_n = (idx == '0);
        end else begin
          idx_n  = idx + SEL_W'(1);
          wrap_n = (idx == IDX_MAX);
        end
      end else begin
        pre_n = pre + PW'(1);
      end
    end
    busy_n = (state_n != IDLE);
    // Output follows the next index so d and idx always agree on the same cycle.
    d_n    = (busy_n && en) ? (OUT_W'(1) << idx_n) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      pre   <= '0;
      wrap  <= 1'b0;
      busy  <= 1'b0;
      d     <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      pre   <= pre_n;
      wrap  <= wrap_n;
      busy  <= busy_n;
      d     <= d_n;
    end
  end

endmodule

// File: tb/tb_decoder_scan_reg.sv
// Bench for decoder_scan_reg: three configurations share stimulus and are compared against a ring model.
module tb_decoder_scan_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0, load = 1'b0, mode = 1'b0, dir = 1'b0, en = 1'b0;
  logic [3:0] s = 4'd0;

  logic [7:0]  d_a, d_b;
  logic [15:0] d_c;
  logic [2:0]  idx_a, idx_b;
  logic [3:0]  idx_c;
  logic        busy_a, busy_b, busy_c, wrap_a, wrap_b, wrap_c;

  decoder_scan_reg #(.SEL_W(3), .DIV(3)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .mode(mode), .dir(dir), .en(en),
    .s(s[2:0]), .d(d_a), .idx(idx_a), .busy(busy_a), .wrap(wrap_a));
  decoder_scan_reg #(.SEL_W(3), .DIV(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .mode(mode), .dir(dir), .en(en),
    .s(s[2:0]), .d(d_b), .idx(idx_b), .busy(busy_b), .wrap(wrap_b));
  decoder_scan_reg #(.SEL_W(4), .DIV(2)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .mode(mode), .dir(dir), .en(en),
    .s(s), .d(d_c), .idx(idx_c), .busy(busy_c), .wrap(wrap_c));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int sel_w[3] = '{3, 3, 4};
  int div_v[3] = '{3, 1, 2};

  // Reference: active flag, scan flag, ring position and prescaler count as plain integers.
  bit  m_active[3];
  bit  m_scan[3];
  int  m_pos[3];
  int  m_cnt[3];
  bit  m_wrap[3];
  logic [15:0] m_d[3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_active[k] = 0; m_scan[k] = 0; m_pos[k] = 0; m_cnt[k] = 0;
      m_wrap[k] = 0;   m_d[k] = '0;
    end
  endtask

  task automatic model_edge();
    int n;
    for (int k = 0; k < 3; k++) begin
      n = 1 << sel_w[k];
      m_wrap[k] = 0;
      if (!rst_n) begin
        m_active[k] = 0; m_scan[k] = 0; m_pos[k] = 0; m_cnt[k] = 0;
      end else if (clr) begin
        m_active[k] = 0; m_scan[k] = 0; m_pos[k] = 0; m_cnt[k] = 0;
      end else if (load) begin
        m_active[k] = 1; m_scan[k] = mode; m_pos[k] = int'(s) % n; m_cnt[k] = 0;
      end else if (m_active[k] && m_scan[k] && en) begin
        m_cnt[k]++;
        if (m_cnt[k] == div_v[k]) begin
          m_cnt[k] = 0;
          if (dir) begin
            m_wrap[k] = (m_pos[k] == 0);
            m_pos[k]  = (m_pos[k] + n - 1) % n;
          end else begin
            m_wrap[k] = (m_pos[k] == n - 1);
            m_pos[k]  = (m_pos[k] + 1) % n;
          end
        end
      end
      m_d[k] = (m_active[k] && en) ? 16'(1 << m_pos[k]) : 16'h0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " a.d"},    64'(d_a),    64'(m_d[0]));
    chk({tag, " a.idx"},  64'(idx_a),  64'(m_pos[0]));
    chk({tag, " a.busy"}, 64'(busy_a), 64'(m_active[0]));
    chk({tag, " a.wrap"}, 64'(wrap_a), 64'(m_wrap[0]));
    chk({tag, " b.d"},    64'(d_b),    64'(m_d[1]));
    chk({tag, " b.idx"},  64'(idx_b),  64'(m_pos[1]));
    chk({tag, " b.busy"}, 64'(busy_b), 64'(m_active[1]));
    chk({tag, " b.wrap"}, 64'(wrap_b), 64'(m_wrap[1]));
    chk({tag, " c.d"},    64'(d_c),    64'(m_d[2]));
    chk({tag, " c.idx"},  64'(idx_c),  64'(m_pos[2]));
    chk({tag, " c.busy"}, 64'(busy_c), 64'(m_active[2]));
    chk({tag, " c.wrap"}, 64'(wrap_c), 64'(m_wrap[2]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all("cyc");
  endtask

  task automatic do_load(input logic [3:0] sv, input logic md, input logic dr);
    s = sv; mode = md; dir = dr; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  int seq_up[10]  = '{6, 6, 6, 7, 7, 7, 0, 0, 0, 1};
  int seq_dn[4]   = '{1, 0, 7, 6};
  int seq_c[5]    = '{14, 14, 15, 15, 0};

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    #1;

    // Static decode
    en = 1'b1;
    do_load(4'd5, 1'b0, 1'b0);
    chk("dec5 d", 64'(d_a), 64'h20);
    chk("dec5 idx", 64'(idx_a), 64'd5);
    chk("dec5 busy", 64'(busy_a), 64'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("dec5 hold", 64'(d_a), 64'h20);
    for (int v = 0; v < 8; v++) begin
      do_load(4'(v), 1'b0, 1'b0);
      chk("sweep d", 64'(d_a), 64'(1 << v));
    end

    // Scan up through the wrap, prescaler 3
    do_load(4'd6, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("up idx", 64'(idx_a), 64'(seq_up[i]));
      chk("up wrap", 64'(wrap_a), 64'(i == 6));
      chk("up onehot", 64'(d_a), 64'(1 << seq_up[i]));
      if (i < 9) tick();
    end

    // Scan down, prescaler 1, then reverse mid-scan
    do_load(4'd1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("dn idx", 64'(idx_b), 64'(seq_dn[i]));
      chk("dn wrap", 64'(wrap_b), 64'(i == 2));
      if (i < 3) tick();
    end
    dir = 1'b0;
    tick();
    chk("dir flip", 64'(idx_b), 64'd7);

    // Enable gating with frozen prescaler phase
    do_load(4'd3, 1'b1, 1'b0);
    tick();
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("gate d", 64'(d_a), 64'h0);
      chk("gate idx", 64'(idx_a), 64'd3);
    end
    en = 1'b1;
    tick();
    chk("ungate d", 64'(d_a), 64'h08);
    tick();
    chk("ungate step", 64'(idx_a), 64'd4);

    // clr beats load
    s = 4'd4; load = 1'b1; clr = 1'b1;
    tick();
    load = 1'b0; clr = 1'b0;
    chk("clr d", 64'(d_a), 64'h0);
    chk("clr idx", 64'(idx_a), 64'd0);
    chk("clr busy", 64'(busy_a), 64'd0);

    // Reload during scan restarts prescaler, no wrap
    do_load(4'd6, 1'b1, 1'b0);
    tick(); tick();
    do_load(4'd2, 1'b1, 1'b0);
    chk("reload idx", 64'(idx_a), 64'd2);
    chk("reload wrap", 64'(wrap_a), 64'd0);
    tick(); tick();
    chk("reload hold", 64'(idx_a), 64'd2);
    tick();
    chk("reload step", 64'(idx_a), 64'd3);
    do_load(4'd0, 1'b1, 1'b1);
    chk("load0 nowrap", 64'(wrap_b), 64'd0);

    // Async reset between edges at idx=7
    do_load(4'd5, 1'b1, 1'b0);
    tick(); tick();
    chk("pre-rst idx", 64'(idx_b), 64'd7);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async");
    chk("async d", 64'(d_b), 64'h0);
    #1;
    rst_n = 1'b1;

    // 16-wide ring, prescaler 2
    do_load(4'd14, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("c idx", 64'(idx_c), 64'(seq_c[i]));
      chk("c wrap", 64'(wrap_c), 64'(i == 4));
      if (i < 4) tick();
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clr  = ($urandom % 50) == 0;
      load = ($urandom % 12) == 0;
      mode = $urandom % 2;
      if (($urandom % 8) == 0) dir = ~dir;
      en   = ($urandom % 10) != 0;
      s    = 4'($urandom);
      if (($urandom % 400) == 0) begin
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rnd async");
        #1;
        rst_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
